// File: rtl/rijndael_inv_simple_func_if.sv
// Byte/key request and result bus of the inverse S-box leakage target.
interface rijndael_inv_simple_func_if;
  logic       valid;
  logic [7:0] din;
  logic [7:0] key;
  logic       busy;
  logic       done;
  logic       trig;
  logic [7:0] dout;

  modport master (output valid, din, key, input busy, done, trig, dout);
  modport slave  (input valid, din, key, output busy, done, trig, dout);
endinterface

// File: rtl/rijndael_inv_simple_func.sv
// Single-byte InvSubBytes + AddRoundKey DPA target; PRECHARGE_EN adds a zero-precharge load state.
// Result with done 3 cycles after acceptance (4 with PRECHARGE_EN); valid is ignored while busy, no queuing.
module rijndael_inv_simple_func #(
  parameter int TRIG_HOLD = 2
) (
  input logic                       clk,
  input logic                       rst,
  rijndael_inv_simple_func_if.slave bus
);

  typedef enum logic [1:0] {LOAD = 2'd0, ISUB = 2'd1, KADD = 2'd2, PCHG = 2'd3} state_t;

  localparam logic [3:0] TRIG_LOAD = (TRIG_HOLD > 15) ? 4'd15 : 4'(TRIG_HOLD);

  state_t     cs, ns;
  logic [7:0] data_reg;
  logic [7:0] key_reg;
  logic [3:0] trig_cnt;
  logic       done_reg;
  logic       accept;
  logic       busy;
`ifdef PRECHARGE_EN
  logic [7:0] din_reg;
`endif

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    logic [7:0] s;
    s = 8'h00;
    case (b)
      8'h00: s = 8'h52; 8'h01: s = 8'h09; 8'h02: s = 8'h6a; 8'h03: s = 8'hd5; 8'h04: s = 8'h30; 8'h05: s = 8'h36; 8'h06: s = 8'ha5; 8'h07: s = 8'h38;
      8'h08: s = 8'hbf; 8'h09: s = 8'h40; 8'h0a: s = 8'ha3; 8'h0b: s = 8'h9e; 8'h0c: s = 8'h81; 8'h0d: s = 8'hf3; 8'h0e: s = 8'hd7; 8'h0f: s = 8'hfb;
      8'h10: s = 8'h7c; 8'h11: s = 8'he3; 8'h12: s = 8'h39; 8'h13: s = 8'h82; 8'h14: s = 8'h9b; 8'h15: s = 8'h2f; 8'h16: s = 8'hff; 8'h17: s = 8'h87;
      8'h18: s = 8'h34; 8'h19: s = 8'h8e; 8'h1a: s = 8'h43; 8'h1b: s = 8'h44; 8'h1c: s = 8'hc4; 8'h1d: s = 8'hde; 8'h1e: s = 8'he9; 8'h1f: s = 8'hcb;
      8'h20: s = 8'h54; 8'h21: s = 8'h7b; 8'h22: s = 8'h94; 8'h23: s = 8'h32; 8'h24: s = 8'ha6; 8'h25: s = 8'hc2; 8'h26: s = 8'h23; 8'h27: s = 8'h3d;
      8'h28: s = 8'hee; 8'h29: s = 8'h4c; 8'h2a: s = 8'h95; 8'h2b: s = 8'h0b; 8'h2c: s = 8'h42; 8'h2d: s = 8'hfa; 8'h2e: s = 8'hc3; 8'h2f: s = 8'h4e;
      8'h30: s = 8'h08; 8'h31: s = 8'h2e; 8'h32: s = 8'ha1; 8'h33: s = 8'h66; 8'h34: s = 8'h28; 8'h35: s = 8'hd9; 8'h36: s = 8'h24; 8'h37: s = 8'hb2;
      8'h38: s = 8'h76; 8'h39: s = 8'h5b; 8'h3a: s = 8'ha2; 8'h3b: s = 8'h49; 8'h3c: s = 8'h6d; 8'h3d: s = 8'h8b; 8'h3e: s = 8'hd1; 8'h3f: s = 8'h25;
      8'h40: s = 8'h72; 8'h41: s = 8'hf8; 8'h42: s = 8'hf6; 8'h43: s = 8'h64; 8'h44: s = 8'h86; 8'h45: s = 8'h68; 8'h46: s = 8'h98; 8'h47: s = 8'h16;
      8'h48: s = 8'hd4; 8'h49: s = 8'ha4; 8'h4a: s = 8'h5c; 8'h4b: s = 8'hcc; 8'h4c: s = 8'h5d; 8'h4d: s = 8'h65; 8'h4e: s = 8'hb6; 8'h4f: s = 8'h92;
      8'h50: s = 8'h6c; 8'h51: s = 8'h70; 8'h52: s = 8'h48; 8'h53: s = 8'h50; 8'h54: s = 8'hfd; 8'h55: s = 8'hed; 8'h56: s = 8'hb9; 8'h57: s = 8'hda;
      8'h58: s = 8'h5e; 8'h59: s = 8'h15; 8'h5a: s = 8'h46; 8'h5b: s = 8'h57; 8'h5c: s = 8'ha7; 8'h5d: s = 8'h8d; 8'h5e: s = 8'h9d; 8'h5f: s = 8'h84;
      8'h60: s = 8'h90; 8'h61: s = 8'hd8; 8'h62: s = 8'hab; 8'h63: s = 8'h00; 8'h64: s = 8'h8c; 8'h65: s = 8'hbc; 8'h66: s = 8'hd3; 8'h67: s = 8'h0a;
      8'h68: s = 8'hf7; 8'h69: s = 8'he4; 8'h6a: s = 8'h58; 8'h6b: s = 8'h05; 8'h6c: s = 8'hb8; 8'h6d: s = 8'hb3; 8'h6e: s = 8'h45; 8'h6f: s = 8'h06;
      8'h70: s = 8'hd0; 8'h71: s = 8'h2c; 8'h72: s = 8'h1e; 8'h73: s = 8'h8f; 8'h74: s = 8'hca; 8'h75: s = 8'h3f; 8'h76: s = 8'h0f; 8'h77: s = 8'h02;
      8'h78: s = 8'hc1; 8'h79: s = 8'haf; 8'h7a: s = 8'hbd; 8'h7b: s = 8'h03; 8'h7c: s = 8'h01; 8'h7d: s = 8'h13; 8'h7e: s = 8'h8a; 8'h7f: s = 8'h6b;
      8'h80: s = 8'h3a; 8'h81: s = 8'h91; 8'h82: s = 8'h11; 8'h83: s = 8'h41; 8'h84: s = 8'h4f; 8'h85: s = 8'h67; 8'h86: s = 8'hdc; 8'h87: s = 8'hea;
      8'h88: s = 8'h97; 8'h89: s = 8'hf2; 8'h8a: s = 8'hcf; 8'h8b: s = 8'hce; 8'h8c: s = 8'hf0; 8'h8d: s = 8'hb4; 8'h8e: s = 8'he6; 8'h8f: s = 8'h73;
      8'h90: s = 8'h96; 8'h91: s = 8'hac; 8'h92: s = 8'h74; 8'h93: s = 8'h22; 8'h94: s = 8'he7; 8'h95: s = 8'had; 8'h96: s = 8'h35; 8'h97: s = 8'h85;
      8'h98: s = 8'he2; 8'h99: s = 8'hf9; 8'h9a: s = 8'h37; 8'h9b: s = 8'he8; 8'h9c: s = 8'h1c; 8'h9d: s = 8'h75; 8'h9e: s = 8'hdf; 8'h9f: s = 8'h6e;
      8'ha0: s = 8'h47; 8'ha1: s = 8'hf1; 8'ha2: s = 8'h1a; 8'ha3: s = 8'h71; 8'ha4: s = 8'h1d; 8'ha5: s = 8'h29; 8'ha6: s = 8'hc5; 8'ha7: s = 8'h89;
      8'ha8: s = 8'h6f; 8'ha9: s = 8'hb7; 8'haa: s = 8'h62; 8'hab: s = 8'h0e; 8'hac: s = 8'haa; 8'had: s = 8'h18; 8'hae: s = 8'hbe; 8'haf: s = 8'h1b;
      8'hb0: s = 8'hfc; 8'hb1: s = 8'h56; 8'hb2: s = 8'h3e; 8'hb3: s = 8'h4b; 8'hb4: s = 8'hc6; 8'hb5: s = 8'hd2; 8'hb6: s = 8'h79; 8'hb7: s = 8'h20;
      8'hb8: s = 8'h9a; 8'hb9: s = 8'hdb; 8'hba: s = 8'hc0; 8'hbb: s = 8'hfe; 8'hbc: s = 8'h78; 8'hbd: s = 8'hcd; 8'hbe: s = 8'h5a; 8'hbf: s = 8'hf4;
      8'hc0: s = 8'h1f; 8'hc1: s = 8'hdd; 8'hc2: s = 8'ha8; 8'hc3: s = 8'h33; 8'hc4: s = 8'h88; 8'hc5: s = 8'h07; 8'hc6: s = 8'hc7; 8'hc7: s = 8'h31;
      8'hc8: s = 8'hb1; 8'hc9: s = 8'h12; 8'hca: s = 8'h10; 8'hcb: s = 8'h59; 8'hcc: s = 8'h27; 8'hcd: s = 8'h80; 8'hce: s = 8'hec; 8'hcf: s = 8'h5f;
      8'hd0: s = 8'h60; 8'hd1: s = 8'h51; 8'hd2: s = 8'h7f; 8'hd3: s = 8'ha9; 8'hd4: s = 8'h19; 8'hd5: s = 8'hb5; 8'hd6: s = 8'h4a; 8'hd7: s = 8'h0d;
      8'hd8: s = 8'h2d; 8'hd9: s = 8'he5; 8'hda: s = 8'h7a; 8'hdb: s = 8'h9f; 8'hdc: s = 8'h93; 8'hdd: s = 8'hc9; 8'hde: s = 8'h9c; 8'hdf: s = 8'hef;
      8'he0: s = 8'ha0; 8'he1: s = 8'he0; 8'he2: s = 8'h3b; 8'he3: s = 8'h4d; 8'he4: s = 8'hae; 8'he5: s = 8'h2a; 8'he6: s = 8'hf5; 8'he7: s = 8'hb0;
      8'he8: s = 8'hc8; 8'he9: s = 8'heb; 8'hea: s = 8'hbb; 8'heb: s = 8'h3c; 8'hec: s = 8'h83; 8'hed: s = 8'h53; 8'hee: s = 8'h99; 8'hef: s = 8'h61;
      8'hf0: s = 8'h17; 8'hf1: s = 8'h2b; 8'hf2: s = 8'h04; 8'hf3: s = 8'h7e; 8'hf4: s = 8'hba; 8'hf5: s = 8'h77; 8'hf6: s = 8'hd6; 8'hf7: s = 8'h26;
      8'hf8: s = 8'he1; 8'hf9: s = 8'h69; 8'hfa: s = 8'h14; 8'hfb: s = 8'h63; 8'hfc: s = 8'h55; 8'hfd: s = 8'h21; 8'hfe: s = 8'h0c; 8'hff: s = 8'h7d;
      default: s = 8'h00;
    endcase
    return s;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) cs <= LOAD;
    else     cs <= ns;
  end

  always_comb begin
    ns = cs;
    case (cs)
`ifdef PRECHARGE_EN
      LOAD:    if (bus.valid) ns = PCHG;
      PCHG:    ns = ISUB;
`else
      LOAD:    if (bus.valid) ns = ISUB;
`endif
      ISUB:    ns = KADD;
      KADD:    ns = LOAD;
      default: ns = LOAD;
    endcase
  end

  always_comb begin
    busy   = (cs != LOAD);
    accept = (cs == LOAD) && bus.valid;
  end

  assign bus.busy = busy;
  assign bus.done = done_reg;
  assign bus.trig = (trig_cnt != 4'd0);
  assign bus.dout = data_reg;

  // data_reg is exposed unmasked every cycle: its transitions are the leakage being measured.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_reg <= 8'h00;
      key_reg  <= 8'h00;
      done_reg <= 1'b0;
      trig_cnt <= 4'd0;
`ifdef PRECHARGE_EN
      din_reg  <= 8'h00;
`endif
    end else begin
      done_reg <= (cs == KADD);
      if (accept)                trig_cnt <= TRIG_LOAD;
      else if (trig_cnt != 4'd0) trig_cnt <= trig_cnt - 4'd1;
      case (cs)
        LOAD: if (bus.valid) begin
          key_reg  <= bus.key;
`ifdef PRECHARGE_EN
          data_reg <= 8'h00;
          din_reg  <= bus.din;
`else
          data_reg <= bus.din;
`endif
        end
`ifdef PRECHARGE_EN
        PCHG: data_reg <= din_reg;
`endif
        ISUB: data_reg <= inv_sbox(data_reg);
        KADD: data_reg <= data_reg ^ key_reg;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rijndael_inv_simple_func.sv
// Directed-vector bench for rijndael_inv_simple_func (inverse S-box + key XOR target).
module tb_rijndael_inv_simple_func;

`ifdef PRECHARGE_EN
  localparam int LAST = 3;
`else
  localparam int LAST = 2;
`endif

  typedef struct {
    logic [7:0] din;
    logic [7:0] key;
    logic [7:0] isub;
    logic [7:0] res;
  } vec_t;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;
  vec_t vecs[8];

  rijndael_inv_simple_func_if bus ();

  rijndael_inv_simple_func #(.TRIG_HOLD(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, " dout"}, bus.dout, 8'h00);
    check({tag, " done"}, {7'd0, bus.done}, 8'h00);
    check({tag, " busy"}, {7'd0, bus.busy}, 8'h00);
    check({tag, " trig"}, {7'd0, bus.trig}, 8'h00);
  endtask

  // One acceptance, then idle inputs (scrambled din/key) until done and one cycle after.
  task automatic run_vec(input vec_t v, input int idx);
    logic [7:0] exp_d;
    bus.valid = 1'b1;
    bus.din   = v.din;
    bus.key   = v.key;
    step();
    bus.valid = 1'b0;
    bus.din   = ~v.din;
    bus.key   = ~v.key;
    for (int k = 0; k <= LAST; k++) begin
      if (k > 0) step();
      if (k == LAST)          exp_d = v.res;
      else if (k == LAST - 1) exp_d = v.isub;
      else if (k == LAST - 2) exp_d = v.din;
      else                    exp_d = 8'h00;
      check($sformatf("vec%0d c%0d dout", idx, k), bus.dout, exp_d);
      check($sformatf("vec%0d c%0d busy", idx, k), {7'd0, bus.busy}, {7'd0, (k < LAST)});
      check($sformatf("vec%0d c%0d done", idx, k), {7'd0, bus.done}, {7'd0, (k == LAST)});
      check($sformatf("vec%0d c%0d trig", idx, k), {7'd0, bus.trig}, {7'd0, (k < 2)});
    end
    step();
    check($sformatf("vec%0d hold dout", idx), bus.dout, v.res);
    check($sformatf("vec%0d hold done", idx), {7'd0, bus.done}, 8'h00);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    vecs[0] = '{din: 8'h63, key: 8'h00, isub: 8'h00, res: 8'h00};
    vecs[1] = '{din: 8'hED, key: 8'h0F, isub: 8'h53, res: 8'h5C};
    vecs[2] = '{din: 8'h16, key: 8'hFF, isub: 8'hFF, res: 8'h00};
    vecs[3] = '{din: 8'h7C, key: 8'h10, isub: 8'h01, res: 8'h11};
    vecs[4] = '{din: 8'h00, key: 8'h00, isub: 8'h52, res: 8'h52};
    vecs[5] = '{din: 8'hFF, key: 8'hA5, isub: 8'h7D, res: 8'hD8};
    vecs[6] = '{din: 8'h52, key: 8'h52, isub: 8'h48, res: 8'h1A};
    vecs[7] = '{din: 8'h01, key: 8'h00, isub: 8'h09, res: 8'h09};

    // Reset held with valid asserted must not start anything.
    rst       = 1'b1;
    bus.valid = 1'b1;
    bus.din   = 8'hAA;
    bus.key   = 8'h00;
    step();
    check_idle("rst c0");
    step();
    check_idle("rst c1");
    rst       = 1'b0;
    bus.valid = 1'b0;
    step();
    check_idle("post rst");

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

`ifndef PRECHARGE_EN
    // Back-to-back with valid held high; new din/key during busy cycles must be ignored.
    bus.valid = 1'b1;
    bus.din   = 8'h7C;
    bus.key   = 8'h10;
    step();
    check("b2b a0 dout", bus.dout, 8'h7C);
    bus.din = 8'h63;
    bus.key = 8'h01;
    step();
    check("b2b a1 dout", bus.dout, 8'h01);
    check("b2b a1 done", {7'd0, bus.done}, 8'h00);
    step();
    check("b2b a2 dout", bus.dout, 8'h11);
    check("b2b a2 done", {7'd0, bus.done}, 8'h01);
    step();
    check("b2b b0 dout", bus.dout, 8'h63);
    check("b2b b0 done", {7'd0, bus.done}, 8'h00);
    check("b2b b0 busy", {7'd0, bus.busy}, 8'h01);
    check("b2b b0 trig", {7'd0, bus.trig}, 8'h01);
    bus.valid = 1'b0;
    step();
    check("b2b b1 dout", bus.dout, 8'h00);
    step();
    check("b2b b2 dout", bus.dout, 8'h01);
    check("b2b b2 done", {7'd0, bus.done}, 8'h01);
    step();
    check("b2b idle done", {7'd0, bus.done}, 8'h00);

    // Reset during ISUB discards the byte and produces no done.
    bus.valid = 1'b1;
    bus.din   = 8'h63;
    bus.key   = 8'h00;
    step();
    bus.valid = 1'b0;
    rst       = 1'b1;
    step();
    check_idle("midrst c0");
    rst = 1'b0;
    step();
    check_idle("midrst c1");
    step();
    check_idle("midrst c2");
    run_vec(vecs[1], 91);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
